// File: rtl/i2c_master_controller.sv
// I2C bus master: START, address byte, data bytes with ACK handling, STOP.
// Write data is popped from a TX FIFO; read data is pushed to an RX FIFO.
// Optional build macro I2C_CLOCK_STRETCH_EN: honour slave clock stretching
// by holding the quarter counter at 0 in q2 while scl_in reads low.
module i2c_master_controller #(
    parameter int QUARTER = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic       rw_mode,
    input  logic [6:0] slave_addr,
    input  logic [7:0] byte_count,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_read_enable,
    output logic [7:0] rx_data,
    output logic       rx_write_enable,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       nack_error,
    output logic       underrun
);
    localparam int CW = $clog2(QUARTER);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_LOAD,
        S_TX_BYTE,
        S_TX_ACK,
        S_RX_BYTE,
        S_RX_ACK,
        S_STOP
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    remaining;
    logic          rw_lat;
    logic          ack_lat;

    logic timing_run;
    logic stretch_hold;
    logic q_last;
    logic sample_pt;
    logic bit_end;
    logic set_nack;
    logic set_under;
    logic finish;

    // Bit timing only runs in states that occupy bus bit slots.
    assign timing_run = (state != S_IDLE) && (state != S_LOAD);

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low at the start of the high phase freezes timing.
    assign stretch_hold = timing_run && (phase == 2'd2) && (qcnt == '0) && !scl_in;
`else
    logic scl_unused;
    assign scl_unused   = scl_in;
    assign stretch_hold = 1'b0;
`endif

    assign q_last    = timing_run && !stretch_hold && (qcnt == CW'(QUARTER - 1));
    assign sample_pt = q_last && (phase == 2'd2);
    assign bit_end   = q_last && (phase == 2'd3);
    assign busy      = (state != S_IDLE);

    // Quarter counter and phase; parked at zero whenever timing is not running.
    always_ff @(posedge clk) begin
        if (rst || !timing_run) begin
            qcnt  <= '0;
            phase <= 2'd0;
        end else if (!stretch_hold) begin
            if (q_last) begin
                qcnt  <= '0;
                phase <= phase + 2'd1;
            end else begin
                qcnt <= qcnt + CW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic and line drive; SCL low in q0/q1, released in q2/q3.
    always_comb begin
        next_state     = state;
        tx_read_enable = 1'b0;
        set_nack       = 1'b0;
        set_under      = 1'b0;
        finish         = 1'b0;
        scl_out        = 1'b1;
        sda_out        = 1'b1;
        case (state)
            S_IDLE: begin
                if (start_req) next_state = S_START;
            end
            S_START: begin
                sda_out = (phase < 2'd2);
                if (bit_end) next_state = S_ADDR;
            end
            S_ADDR: begin
                scl_out = phase[1];
                sda_out = shreg[7];
                if (bit_end && bit_idx == 3'd7) next_state = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                scl_out = phase[1];
                if (bit_end) begin
                    if (ack_lat) begin
                        set_nack   = 1'b1;
                        next_state = S_STOP;
                    end else if (remaining == 8'd0) begin
                        next_state = S_STOP;
                    end else if (rw_lat) begin
                        next_state = S_RX_BYTE;
                    end else begin
                        next_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                scl_out = 1'b0;
                if (tx_empty) begin
                    set_under  = 1'b1;
                    next_state = S_STOP;
                end else begin
                    tx_read_enable = 1'b1;
                    next_state     = S_TX_BYTE;
                end
            end
            S_TX_BYTE: begin
                scl_out = phase[1];
                sda_out = shreg[7];
                if (bit_end && bit_idx == 3'd7) next_state = S_TX_ACK;
            end
            S_TX_ACK: begin
                scl_out = phase[1];
                if (bit_end) begin
                    if (ack_lat) begin
                        set_nack   = 1'b1;
                        next_state = S_STOP;
                    end else if (remaining <= 8'd1) begin
                        next_state = S_STOP;
                    end else begin
                        next_state = S_LOAD;
                    end
                end
            end
            S_RX_BYTE: begin
                scl_out = phase[1];
                if (bit_end && bit_idx == 3'd7) next_state = S_RX_ACK;
            end
            S_RX_ACK: begin
                scl_out = phase[1];
                // ACK while more bytes are wanted, NACK on the final byte.
                sda_out = (remaining <= 8'd1);
                if (bit_end) next_state = (remaining <= 8'd1) ? S_STOP : S_RX_BYTE;
            end
            S_STOP: begin
                scl_out = (phase != 2'd0);
                sda_out = phase[1];
                if (bit_end) begin
                    finish     = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: request latch, shift register, byte counter, status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx         <= 3'd0;
            shreg           <= 8'h00;
            remaining       <= 8'h00;
            rw_lat          <= 1'b0;
            ack_lat         <= 1'b0;
            rx_data         <= 8'h00;
            rx_write_enable <= 1'b0;
            done            <= 1'b0;
            nack_error      <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            done            <= finish;
            rx_write_enable <= 1'b0;
            if (set_nack)  nack_error <= 1'b1;
            if (set_under) underrun   <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        rw_lat     <= rw_mode;
                        remaining  <= byte_count;
                        shreg      <= {slave_addr, rw_mode};
                        bit_idx    <= 3'd0;
                        nack_error <= 1'b0;
                        underrun   <= 1'b0;
                    end
                end
                S_ADDR, S_TX_BYTE: begin
                    if (bit_end) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                S_ADDR_ACK: begin
                    if (sample_pt) ack_lat <= sda_in;
                end
                S_LOAD: begin
                    if (!tx_empty) begin
                        shreg   <= tx_data;
                        bit_idx <= 3'd0;
                    end
                end
                S_TX_ACK: begin
                    if (sample_pt) ack_lat <= sda_in;
                    if (bit_end && remaining != 8'd0) remaining <= remaining - 8'd1;
                end
                S_RX_BYTE: begin
                    if (sample_pt) begin
                        shreg <= {shreg[6:0], sda_in};
                        if (bit_idx == 3'd7) begin
                            rx_data         <= {shreg[6:0], sda_in};
                            rx_write_enable <= 1'b1;
                        end
                    end
                    if (bit_end) bit_idx <= bit_idx + 3'd1;
                end
                S_RX_ACK: begin
                    if (bit_end && remaining != 8'd0) remaining <= remaining - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Testbench for i2c_master_controller: behavioural I2C slave on the bus,
// FIFO models, a transaction-level reference model, directed table plus
// random transactions, reset-abort and (with I2C_CLOCK_STRETCH_EN) stretching.
module tb_i2c_master_controller;
    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_req = 1'b0;
    logic       rw_mode = 1'b0;
    logic [6:0] slave_addr = 7'h00;
    logic [7:0] byte_count = 8'h00;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_read_enable;
    logic [7:0] rx_data;
    logic       rx_write_enable;
    logic       sda_in, scl_in, scl_out, sda_out;
    logic       busy, done, nack_error, underrun;
    logic       sda_slave = 1'b1;
    logic       scl_slave = 1'b1;

    i2c_master_controller #(.QUARTER(Q)) dut (
        .clk(clk), .rst(rst), .start_req(start_req), .rw_mode(rw_mode),
        .slave_addr(slave_addr), .byte_count(byte_count), .tx_data(tx_data),
        .tx_empty(tx_empty), .tx_read_enable(tx_read_enable), .rx_data(rx_data),
        .rx_write_enable(rx_write_enable), .sda_in(sda_in), .scl_in(scl_in),
        .scl_out(scl_out), .sda_out(sda_out), .busy(busy), .done(done),
        .nack_error(nack_error), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND bus.
    assign sda_in = sda_out & sda_slave;
    assign scl_in = scl_out & scl_slave;

    typedef struct {
        logic [6:0]      addr;
        logic            rw;
        logic [7:0]      cnt;
        int              nfifo;
        logic [3:0][7:0] fifo;
        logic            aack;
        logic [3:0]      dack;
        logic [3:0][7:0] rd;
        logic            e_nack;
        logic            e_under;
        int              e_pops;
        int              e_rx;
    } vec_t;

    int checks = 0;
    int fails  = 0;

    // TX FIFO model: head index follows the number of pops seen.
    logic [3:0][7:0] fifo_mem = '0;
    int fifo_n = 0, fifo_base = 0, pops_total = 0, head;
    bit pop_pend = 0;
    int dones_total = 0;
    logic [7:0] rx_got[$];
    assign head     = pops_total - fifo_base;
    assign tx_empty = (head >= fifo_n);
    assign tx_data  = tx_empty ? 8'h00 : fifo_mem[head[1:0]];

    always @(negedge clk) begin
        if (pop_pend) pops_total++;
        pop_pend = tx_read_enable;
        if (done) dones_total++;
        if (rx_write_enable) rx_got.push_back(rx_data);
    end

    // Behavioural slave: frames of 9 bits, ACK/data driven after SCL falls.
    vec_t cfg;
    bit   active = 0;
    int   bitpos = -1;
    int   cyc = 0, hi_start = 0;
    bit   cap_q[$];
    int   hi_q[$];
    logic prev_scl = 1'b1, prev_sda = 1'b1, prev_sclo = 1'b1;
    always @(negedge clk) begin
        logic sc, sd;
        int fr, ix;
        cyc++;
        sc = scl_in;
        sd = sda_in;
        if (rst) begin
            active    = 0;
            bitpos    = -1;
            sda_slave = 1'b1;
        end else begin
            if (prev_scl && sc && prev_sda && !sd) begin
                active = 1; bitpos = -1; sda_slave = 1'b1;
                cap_q.delete(); hi_q.delete();
            end else if (prev_scl && sc && !prev_sda && sd) begin
                active = 0; sda_slave = 1'b1;
            end else if (active && !prev_scl && sc) begin
                cap_q.push_back(sd);
            end else if (active && prev_scl && !sc) begin
                bitpos++;
                fr = bitpos / 9;
                ix = bitpos % 9;
                sda_slave = 1'b1;
                if (fr == 0 && ix == 8) sda_slave = !cfg.aack;
                else if (fr >= 1 && fr <= 4 && cfg.aack) begin
                    if (!cfg.rw && ix == 8) sda_slave = !cfg.dack[fr-1];
                    else if (cfg.rw && ix < 8 && fr <= int'(cfg.cnt)) sda_slave = cfg.rd[fr-1][7-ix];
                end
            end
            if (!prev_sclo && scl_out) hi_start = cyc;
            if (prev_sclo && !scl_out && active) hi_q.push_back(cyc - hi_start);
        end
        prev_scl  = sc;
        prev_sda  = sd;
        prev_sclo = scl_out;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference model: expected bus bits (SCL-high samples incl. the STOP
    // setup bit), RX bytes, pops and error flags from the protocol rules.
    bit         exp_bits[$];
    logic [7:0] exp_rx[$];
    int  m_pops;
    bit  m_nack, m_under;

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
    endtask

    task automatic build_model(input vec_t v);
        exp_bits.delete(); exp_rx.delete();
        m_pops = 0; m_nack = 0; m_under = 0;
        push_byte({v.addr, v.rw});
        exp_bits.push_back(!v.aack);
        if (!v.aack) m_nack = 1;
        else begin
            for (int i = 0; i < int'(v.cnt); i++) begin
                if (v.rw) begin
                    push_byte(v.rd[i]);
                    exp_rx.push_back(v.rd[i]);
                    exp_bits.push_back(i == int'(v.cnt) - 1);
                end else begin
                    if (i >= v.nfifo) begin m_under = 1; break; end
                    m_pops++;
                    push_byte(v.fifo[i]);
                    exp_bits.push_back(!v.dack[i]);
                    if (!v.dack[i]) begin m_nack = 1; break; end
                end
            end
        end
        exp_bits.push_back(1'b0);
    endtask

    task automatic run_txn(input string nm, input vec_t v, input bit poke, input bit stretch);
        int t, w, d0, p0, rb, mism;
        bit st_done;
        cfg = v; fifo_mem = v.fifo; fifo_n = v.nfifo; fifo_base = pops_total;
        build_model(v);
        d0 = dones_total; p0 = pops_total; rb = rx_got.size(); st_done = 0;
        @(negedge clk);
        slave_addr = v.addr; rw_mode = v.rw; byte_count = v.cnt; start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        chk({nm, "_busy_on"}, int'(busy), 1);
        chk({nm, "_flags_clr"}, int'({nack_error, underrun}), 0);
        t = 0;
        while (dones_total == d0 && t < 30000) begin
            @(negedge clk);
            t++;
            start_req = (poke && t == 60);
            if (poke && t == 60) begin slave_addr = ~v.addr; byte_count = 8'd9; end
            if (stretch && !st_done && active && bitpos == 5 && !scl_out) begin
                scl_slave = 1'b0;
                w = 0;
                while (!scl_out && w < 1000) begin @(negedge clk); w++; end
                repeat (40) @(negedge clk);
                scl_slave = 1'b1;
                st_done = 1;
            end
        end
        start_req = 1'b0;
        chk({nm, "_timeout"}, int'(t >= 30000), 0);
        repeat (4) @(negedge clk);
        chk({nm, "_done_cnt"}, dones_total - d0, 1);
        chk({nm, "_busy_off"}, int'(busy), 0);
        chk({nm, "_nack"}, int'(nack_error), int'(v.e_nack));
        chk({nm, "_underrun"}, int'(underrun), int'(v.e_under));
        chk({nm, "_pops"}, pops_total - p0, v.e_pops);
        chk({nm, "_rx_cnt"}, rx_got.size() - rb, v.e_rx);
        mism = 0;
        if (cap_q.size() != exp_bits.size()) mism = 1000 + cap_q.size();
        else foreach (exp_bits[i]) if (cap_q[i] != exp_bits[i]) mism++;
        chk({nm, "_bus_bits"}, mism, 0);
        mism = 0;
        if (rx_got.size() - rb != exp_rx.size()) mism = 1000;
        else foreach (exp_rx[i]) if (rx_got[rb+i] != exp_rx[i]) mism++;
        chk({nm, "_rx_data"}, mism, 0);
        if (hi_q.size() > 6) begin
            if (stretch) chk({nm, "_stretch_hi"}, int'(hi_q[6] >= 2*Q+38 && hi_q[6] <= 2*Q+42), 1);
            else         chk({nm, "_hi_len"}, hi_q[6], 2*Q);
        end
    endtask

    vec_t tbl[7];
    vec_t v;
    int   d0, t;

    initial begin
        //          addr   rw   cnt  nf fifo          aack dack  rd            nack under pops rx
        tbl[0] = '{7'h5A, 1'b0, 8'd2, 2, 32'h0000A53C, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 2, 0};
        tbl[1] = '{7'h21, 1'b1, 8'd3, 0, 32'h0,        1'b1, 4'hF, 32'h00332211, 1'b0, 1'b0, 0, 3};
        tbl[2] = '{7'h10, 1'b0, 8'd2, 2, 32'h0000BEEF, 1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 0, 0};
        tbl[3] = '{7'h44, 1'b0, 8'd2, 1, 32'h00000077, 1'b1, 4'hF, 32'h0,        1'b0, 1'b1, 1, 0};
        tbl[4] = '{7'h3F, 1'b0, 8'd0, 1, 32'h000000EE, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 0, 0};
        tbl[5] = '{7'h62, 1'b0, 8'd3, 3, 32'h00CCBBAA, 1'b1, 4'hE, 32'h0,        1'b1, 1'b0, 1, 0};
        tbl[6] = '{7'h7F, 1'b1, 8'd1, 0, 32'h0,        1'b1, 4'hF, 32'h00000096, 1'b0, 1'b0, 0, 1};

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_scl", int'(scl_out), 1);
        chk("rst_sda", int'(sda_out), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_nack", int'(nack_error), 0);
        chk("rst_under", int'(underrun), 0);
        chk("rst_txre", int'(tx_read_enable), 0);
        chk("rst_rxwe", int'(rx_write_enable), 0);
        chk("rst_rxdata", int'(rx_data), 0);

        foreach (tbl[i]) run_txn($sformatf("tbl%0d", i), tbl[i], 1'b0, 1'b0);

        // Random transactions against the reference model; some also poke
        // start_req while busy, which must be ignored.
        for (int n = 0; n < 8; n++) begin
            v.addr  = 7'($urandom);
            v.rw    = 1'($urandom_range(0, 1));
            v.cnt   = 8'($urandom_range(0, 4));
            v.nfifo = $urandom_range(0, 4);
            if ($urandom_range(0, 3) != 0 && v.nfifo < int'(v.cnt)) v.nfifo = int'(v.cnt);
            v.fifo  = 32'($urandom);
            v.rd    = 32'($urandom);
            v.aack  = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < 4; k++) v.dack[k] = ($urandom_range(0, 5) != 0);
            build_model(v);
            v.e_nack = m_nack; v.e_under = m_under; v.e_pops = m_pops; v.e_rx = exp_rx.size();
            run_txn($sformatf("rnd%0d", n), v, 1'(n % 2), 1'b0);
        end

        // Reset during the 4th bit of the first data byte: lines release at once,
        // no done pulse, then a fresh transaction completes normally.
        cfg = tbl[0]; fifo_mem = tbl[0].fifo; fifo_n = tbl[0].nfifo; fifo_base = pops_total;
        d0 = dones_total;
        @(negedge clk);
        slave_addr = 7'h33; rw_mode = 1'b0; byte_count = 8'd2; start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        t = 0;
        while (!(active && bitpos == 12) && t < 5000) begin @(negedge clk); t++; end
        chk("abort_reach_bit3", int'(t < 5000), 1);
        repeat (2*Q + 1) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_scl", int'(scl_out), 1);
        chk("abort_sda", int'(sda_out), 1);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", dones_total - d0, 0);
        run_txn("after_abort", tbl[0], 1'b0, 1'b0);

`ifdef I2C_CLOCK_STRETCH_EN
        run_txn("stretch", tbl[0], 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
